// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU codes,
// instruction Op, data-processing command and condition encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTER = 4'd6,
        ST_EXECUTEI = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9
    } state_e;

    localparam int unsigned ALU_CODE_W = 3;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_CODE_W-1:0] ALU_ORR = 3'b011;
    localparam logic [ALU_CODE_W-1:0] ALU_EOR = 3'b100;
    localparam logic [ALU_CODE_W-1:0] ALU_MOV = 3'b101;
    localparam logic [ALU_CODE_W-1:0] ALU_BIC = 3'b110;

    localparam logic [1:0] OP_DP   = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;
    localparam logic [1:0] OP_BR   = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    // Data-processing command field Funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_TEQ = 4'b1001;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_BIC = 4'b1110;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/mc_controlunit_cond_check.sv
// Condition evaluator: ARM condition field against stored NZCV; 1111 acts as AL.
module cond_check
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       cond_ex
);

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = nzcv;

    // Decode the condition field into a single pass/fail bit
    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            COND_EQ: cond_ex = flag_z;
            COND_NE: cond_ex = !flag_z;
            COND_CS: cond_ex = flag_c;
            COND_CC: cond_ex = !flag_c;
            COND_MI: cond_ex = flag_n;
            COND_PL: cond_ex = !flag_n;
            COND_VS: cond_ex = flag_v;
            COND_VC: cond_ex = !flag_v;
            COND_HI: cond_ex = flag_c && !flag_z;
            COND_LS: cond_ex = !flag_c || flag_z;
            COND_GE: cond_ex = (flag_n == flag_v);
            COND_LT: cond_ex = (flag_n != flag_v);
            COND_GT: cond_ex = !flag_z && (flag_n == flag_v);
            COND_LE: cond_ex = flag_z || (flag_n != flag_v);
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controlunit.sv
// Multicycle ARM control unit: FSM sequencing, ALU decode and NZCV flag store.
// Optional macro MC_CTRL_EXT_ALU_EN adds TST/TEQ/CMN/MOV/BIC decode.
// Control outputs are combinational from State/Instr (plus MemReady where a
// state waits on memory); Flags only reaches the NZCV register.
module mc_controlunit
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUC_W      = 3,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Instr,
    input  logic [3:0]        Flags,
    input  logic              MemReady,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              RegWrite,
    output logic [1:0]        ResultSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [ALUC_W-1:0] ALUControl,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic [3:0]        State
);

    state_e state_q;
    state_e state_d;
    logic [3:0] nzcv_q;
    logic [3:0] nzcv_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       s_bit;
    logic       rd_is_pc;
    logic       cond_ex;

    logic [ALU_CODE_W-1:0] alu_dec;
    logic                  dec_known;
    logic                  dec_cv;
    logic                  dec_wr_ok;
    logic [1:0]            flag_w;

    logic                  pc_write_c;
    logic                  mem_write_c;
    logic                  ir_write_c;
    logic                  reg_write_c;
    logic [ALU_CODE_W-1:0] alu_ctrl_c;

    logic unused_instr_bits;

    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign cmd      = funct[4:1];
    assign s_bit    = funct[0];
    assign rd_is_pc = (Instr[15:12] == 4'd15);

    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    cond_check u_cond_check (
        .cond    (cond),
        .nzcv    (nzcv_q),
        .cond_ex (cond_ex)
    );

    // Data-processing decode: ALU code, flag-write class and write permission
    always_comb begin
        alu_dec   = ALU_ADD;
        dec_known = 1'b1;
        dec_cv    = 1'b0;
        dec_wr_ok = 1'b1;
        case (cmd)
            CMD_ADD: begin alu_dec = ALU_ADD; dec_cv = 1'b1; end
            CMD_SUB: begin alu_dec = ALU_SUB; dec_cv = 1'b1; end
            CMD_AND: alu_dec = ALU_AND;
            CMD_ORR: alu_dec = ALU_ORR;
            CMD_EOR: alu_dec = ALU_EOR;
            CMD_CMP: begin alu_dec = ALU_SUB; dec_cv = 1'b1; dec_wr_ok = 1'b0; end
`ifdef MC_CTRL_EXT_ALU_EN
            CMD_TST: begin alu_dec = ALU_AND; dec_wr_ok = 1'b0; end
            CMD_TEQ: begin alu_dec = ALU_EOR; dec_wr_ok = 1'b0; end
            CMD_CMN: begin alu_dec = ALU_ADD; dec_cv = 1'b1; dec_wr_ok = 1'b0; end
            CMD_MOV: alu_dec = ALU_MOV;
            CMD_BIC: alu_dec = ALU_BIC;
`endif
            default: begin
                alu_dec   = ALU_ADD;
                dec_known = 1'b0;
                dec_wr_ok = 1'b0;
            end
        endcase
        flag_w = {s_bit && dec_known, s_bit && dec_known && dec_cv};
    end

    // Next state, flag update and per-state control values
    always_comb begin
        state_d     = state_q;
        nzcv_d      = nzcv_q;
        pc_write_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        alu_ctrl_c  = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                ResultSrc  = 2'b10;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                pc_write_c = MemReady;
                ir_write_c = MemReady;
                if (MemReady) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ResultSrc = 2'b10;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                case (op)
                    OP_MEM:  state_d = ST_MEMADR;
                    OP_DP:   state_d = funct[5] ? ST_EXECUTEI : ST_EXECUTER;
                    OP_BR:   state_d = ST_BRANCH;
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = funct[0] ? ST_MEMREAD : ST_MEMWRITE;
            end
            ST_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = ST_MEMWB;
            end
            ST_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = cond_ex && MemReady;
                if (MemReady) state_d = ST_FETCH;
            end
            ST_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = cond_ex;
                pc_write_c  = cond_ex && rd_is_pc;
                state_d     = ST_FETCH;
            end
            ST_EXECUTER, ST_EXECUTEI: begin
                ALUSrcB    = (state_q == ST_EXECUTEI) ? 2'b01 : 2'b00;
                alu_ctrl_c = alu_dec;
                if (cond_ex && flag_w[1]) nzcv_d[3:2] = Flags[3:2];
                if (cond_ex && flag_w[0]) nzcv_d[1:0] = Flags[1:0];
                state_d = ST_ALUWB;
            end
            ST_ALUWB: begin
                reg_write_c = cond_ex && dec_wr_ok;
                pc_write_c  = cond_ex && dec_wr_ok && rd_is_pc;
                state_d     = ST_FETCH;
            end
            ST_BRANCH: begin
                ResultSrc  = 2'b10;
                ALUSrcB    = 2'b01;
                pc_write_c = cond_ex;
                state_d    = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // State and NZCV registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            nzcv_q  <= RESET_FLAGS;
        end else begin
            state_q <= state_d;
            nzcv_q  <= nzcv_d;
        end
    end

    // Strobes are suppressed during the reset cycle so nothing commits
    assign PCWrite    = pc_write_c  && !reset;
    assign MemWrite   = mem_write_c && !reset;
    assign IRWrite    = ir_write_c  && !reset;
    assign RegWrite   = reg_write_c && !reset;
    assign ALUControl = ALUC_W'(alu_ctrl_c);
    assign ImmSrc     = op;
    assign RegSrc     = {(op == OP_MEM) && !funct[0], (op == OP_BR)};
    assign State      = state_q;

endmodule

// File: tb/tb_mc_controlunit.sv
// Self-checking bench for mc_controlunit: directed instruction scenarios then
// random instructions, with MemReady/Flags randomized, against an
// instruction-level reference model.
module tb_mc_controlunit;
    import mc_ctrl_pkg::*;

    localparam logic [3:0] RST_FLAGS = 4'b1010;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  Flags;
    logic        MemReady;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic [3:0]  State;

    mc_controlunit #(.ALUC_W(3), .RESET_FLAGS(RST_FLAGS)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .Flags      (Flags),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_cyc = 0;

    logic [3:0]  nzcv_m;
    logic        mr_now;
    bit          mr_q[$];
    logic        fl_fixed_en = 1'b0;
    logic [3:0]  fl_fixed = 4'b0000;
    logic        next_valid = 1'b0;
    logic [31:0] next_instr = 32'h0;
    logic [1:0]  e_imm;
    logic [1:0]  e_regsrc;
    logic [8:0]  sel;

    assign sel = {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ARM condition semantics: even codes test a predicate, odd codes its negation
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return (c[3:1] == 3'd7) ? 1'b1 : (base ^ c[0]);
    endfunction

    // Instruction-level meaning of a data-processing command
    task automatic dp_decode(input logic [3:0] c, input logic s,
                             output logic [2:0] aluc, output logic [1:0] fw, output logic wr);
        logic known, cv;
        known = 1'b1; cv = 1'b0; wr = 1'b1; aluc = 3'd0;
        case (c)
            4'b0100: begin aluc = 3'd0; cv = 1'b1; end
            4'b0010: begin aluc = 3'd1; cv = 1'b1; end
            4'b0000: aluc = 3'd2;
            4'b1100: aluc = 3'd3;
            4'b0001: aluc = 3'd4;
            4'b1010: begin aluc = 3'd1; cv = 1'b1; wr = 1'b0; end
`ifdef MC_CTRL_EXT_ALU_EN
            4'b1000: begin aluc = 3'd2; wr = 1'b0; end
            4'b1001: begin aluc = 3'd4; wr = 1'b0; end
            4'b1011: begin aluc = 3'd0; cv = 1'b1; wr = 1'b0; end
            4'b1101: aluc = 3'd5;
            4'b1110: aluc = 3'd6;
`endif
            default: begin known = 1'b0; wr = 1'b0; end
        endcase
        fw = {s && known, s && known && cv};
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        n_cyc++;
        if (n_cyc > 50000) begin
            $display("FAIL cycle_budget: got %0d cycles expected at most 50000", n_cyc);
            $fatal(1, "cycle budget exhausted");
        end
        if (next_valid) begin
            Instr = next_instr;
            next_valid = 1'b0;
        end
        if (mr_q.size() > 0) mr_now = mr_q.pop_front();
        else mr_now = ($urandom_range(0, 3) != 0);
        MemReady = mr_now;
        Flags = fl_fixed_en ? fl_fixed : 4'($urandom);
        #1;
    endtask

    task automatic expect_cycle(input state_e es, input logic pcw, input logic mw,
                                input logic irw, input logic rw,
                                input logic [8:0] ex, input logic [8:0] mk);
        check("State", 32'(State), 32'(es));
        check("PCWrite", 32'(PCWrite), 32'(pcw));
        check("MemWrite", 32'(MemWrite), 32'(mw));
        check("IRWrite", 32'(IRWrite), 32'(irw));
        check("RegWrite", 32'(RegWrite), 32'(rw));
        check("selects", 32'(sel & mk), 32'(ex & mk));
        check("ImmSrc", 32'(ImmSrc), 32'(e_imm));
        check("RegSrc", 32'(RegSrc), 32'(e_regsrc));
    endtask

    task automatic fetch_decode(input logic [31:0] instr);
        next_instr = instr;
        next_valid = 1'b1;
        e_imm      = instr[27:26];
        e_regsrc   = {(instr[27:26] == 2'b01) && !instr[20], instr[27:26] == 2'b10};
        do begin
            begin_cycle();
            expect_cycle(ST_FETCH, mr_now, 1'b0, mr_now, 1'b0, 9'b0_10_1_10_000, 9'h1FF);
        end while (!mr_now);
        begin_cycle();
        expect_cycle(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0_10_1_10_000, 9'b0_11_1_11_000);
    endtask

    task automatic run_instr(input logic [31:0] instr);
        logic [3:0] cond;
        logic [2:0] aluc;
        logic [1:0] fw;
        logic       wr, ce, rd15, imm;
        cond = instr[31:28];
        rd15 = (instr[15:12] == 4'hF);
        imm  = instr[25];
        dp_decode(instr[24:21], instr[20], aluc, fw, wr);
        fetch_decode(instr);
        case (instr[27:26])
            2'b01: begin
                begin_cycle();
                expect_cycle(ST_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0_00_0_01_000, 9'b0_00_1_11_111);
                if (instr[20]) begin
                    do begin
                        begin_cycle();
                        expect_cycle(ST_MEMREAD, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1_00_0_00_000, 9'b1_11_0_00_000);
                    end while (!mr_now);
                    begin_cycle();
                    ce = cond_ok(cond, nzcv_m);
                    expect_cycle(ST_MEMWB, ce && rd15, 1'b0, 1'b0, ce, 9'b0_01_0_00_000, 9'b0_11_0_00_000);
                end else begin
                    do begin
                        begin_cycle();
                        ce = cond_ok(cond, nzcv_m);
                        expect_cycle(ST_MEMWRITE, 1'b0, ce && mr_now, 1'b0, 1'b0, 9'b1_00_0_00_000, 9'b1_00_0_00_000);
                    end while (!mr_now);
                end
            end
            2'b00: begin
                begin_cycle();
                ce = cond_ok(cond, nzcv_m);
                expect_cycle(imm ? ST_EXECUTEI : ST_EXECUTER, 1'b0, 1'b0, 1'b0, 1'b0,
                             {4'b0_00_0, imm ? 2'b01 : 2'b00, aluc}, 9'b0_00_1_11_111);
                check("flag_w", 32'(dut.flag_w), 32'(fw));
                if (ce && fw[1]) nzcv_m[3:2] = Flags[3:2];
                if (ce && fw[0]) nzcv_m[1:0] = Flags[1:0];
                begin_cycle();
                ce = cond_ok(cond, nzcv_m);
                expect_cycle(ST_ALUWB, ce && wr && rd15, 1'b0, 1'b0, ce && wr, 9'b0_00_0_00_000, 9'b0_11_0_00_000);
            end
            2'b10: begin
                begin_cycle();
                ce = cond_ok(cond, nzcv_m);
                expect_cycle(ST_BRANCH, ce, 1'b0, 1'b0, 1'b0, 9'b0_10_0_01_000, 9'b0_11_1_11_111);
            end
            default: ;
        endcase
        check("nzcv", 32'(dut.nzcv_q), 32'(nzcv_m));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int unsigned k;
        w = $urandom;
        if ($urandom_range(0, 2) == 0) w[31:28] = 4'hE;
        k = $urandom_range(0, 9);
        if (k < 5) begin
            w[27:26] = 2'b00;
            case ($urandom_range(0, 10))
                0:       w[24:21] = 4'b0100;
                1:       w[24:21] = 4'b0010;
                2:       w[24:21] = 4'b0000;
                3:       w[24:21] = 4'b1100;
                4:       w[24:21] = 4'b0001;
                5:       w[24:21] = 4'b1010;
                6:       w[24:21] = 4'b1000;
                7:       w[24:21] = 4'b1001;
                8:       w[24:21] = 4'b1011;
                9:       w[24:21] = 4'b1101;
                default: w[24:21] = 4'b1110;
            endcase
        end else if (k < 8) w[27:26] = 2'b01;
        else if (k == 8) w[27:26] = 2'b10;
        else w[27:26] = 2'b11;
        if ($urandom_range(0, 4) == 0) w[15:12] = 4'hF;
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        MemReady = 1'b1;
        Instr    = 32'hE0821003;
        Flags    = 4'b0000;
        nzcv_m   = RST_FLAGS;
        e_imm    = 2'b00;
        e_regsrc = 2'b00;
        mr_now   = 1'b0;

        // Reset: FETCH loaded, strobes held low even with MemReady high
        repeat (2) @(negedge clk);
        #1;
        check("rst_State", 32'(State), 32'(ST_FETCH));
        check("rst_PCWrite", 32'(PCWrite), 32'd0);
        check("rst_IRWrite", 32'(IRWrite), 32'd0);
        check("rst_MemWrite", 32'(MemWrite), 32'd0);
        check("rst_RegWrite", 32'(RegWrite), 32'd0);
        check("rst_nzcv", 32'(dut.nzcv_q), 32'(RST_FLAGS));
        @(negedge clk);
        reset    = 1'b0;
        MemReady = 1'b0;

        // ADD R1,R2,R3 with memory always ready
        repeat (4) mr_q.push_back(1'b1);
        run_instr(32'hE0821003);

        // LDR with three MemReady-low cycles in MEMREAD
        mr_q.push_back(1'b1); mr_q.push_back(1'b1); mr_q.push_back(1'b1);
        mr_q.push_back(1'b0); mr_q.push_back(1'b0); mr_q.push_back(1'b0);
        mr_q.push_back(1'b1); mr_q.push_back(1'b1);
        run_instr(32'hE5912004);

        // SUBS setting Z, then BEQ taken; then SUBS clearing Z, BEQ not taken
        fl_fixed_en = 1'b1;
        fl_fixed    = 4'b0100;
        run_instr(32'hE0500001);
        check("z_stored", 32'(dut.nzcv_q[2]), 32'd1);
        run_instr(32'h0A000002);
        fl_fixed = 4'b0000;
        run_instr(32'hE0500001);
        run_instr(32'h0A000002);

        // CMP R0,#5 writes all flags but no register
        fl_fixed = 4'b1001;
        run_instr(32'hE3500005);
        check("cmp_nzcv", 32'(dut.nzcv_q), 32'h9);

        // TST: extended decode writes NZ only; default decode writes nothing
        fl_fixed = 4'b1111;
        run_instr(32'hE1100001);

        // Reset during a MEMWRITE stall after flags were set to 1111
        run_instr(32'hE0500001);
        fetch_decode(32'hE5802004);
        mr_q.push_back(1'b1); mr_q.push_back(1'b0);
        begin_cycle();
        expect_cycle(ST_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0_00_0_01_000, 9'b0_00_1_11_111);
        begin_cycle();
        expect_cycle(ST_MEMWRITE, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1_00_0_00_000, 9'b1_00_0_00_000);
        @(negedge clk);
        reset    = 1'b1;
        MemReady = 1'b1;
        #1;
        check("rstmw_MemWrite", 32'(MemWrite), 32'd0);
        check("rstmw_PCWrite", 32'(PCWrite), 32'd0);
        check("rstmw_State", 32'(State), 32'(ST_MEMWRITE));
        @(negedge clk);
        reset    = 1'b0;
        MemReady = 1'b0;
        #1;
        nzcv_m = RST_FLAGS;
        check("rstmw_State_after", 32'(State), 32'(ST_FETCH));
        check("rstmw_nzcv", 32'(dut.nzcv_q), 32'(RST_FLAGS));

        // Random instruction stream with random MemReady and Flags
        fl_fixed_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            run_instr(rand_instr());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
